// File: rtl/imm_pkg.sv
// Shared definitions for the RISC-V immediate encoder: format selector,
// field-width constants and the signed-fit helper.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I   = 3'd0,
    IMM_S   = 3'd1,
    IMM_SB  = 3'd2,
    IMM_U   = 3'd3,
    IMM_UJ  = 3'd4,
    IMM_RAW = 3'd5
  } imm_fmt_t;

  localparam int IMM_W   = 64;
  localparam int INSTR_W = 32;

  // Highest immediate bit that still carries information for each format;
  // everything from this bit up must be a pure sign extension.
  localparam int I_MSB   = 11;
  localparam int S_MSB   = 11;
  localparam int SB_MSB  = 12;
  localparam int U_MSB   = 31;
  localparam int UJ_MSB  = 20;
  localparam int RAW_MSB = 31;

  localparam int U_ALIGN_W = 12;

  // 1 iff imm[63:msb] are all equal (imm fits in msb+1 signed bits).
  function automatic logic fits_signed(input logic [IMM_W-1:0] imm, input int msb);
    logic [IMM_W-1:0] top;
    top = $signed(imm) >>> msb;
    return (top == '0) || (top == '1);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: scatters a signed immediate into the instruction
// fields of the selected format and reports whether it is representable.
module imm_pack
  import imm_pkg::*;
(
  input  logic [2:0]         sel,
  input  logic [IMM_W-1:0]   imm,
  input  logic [INSTR_W-1:0] base,
  output logic [INSTR_W-1:0] instr,
  output logic               legal
);

  always_comb begin
    instr = base;
    legal = 1'b0;
    case (sel)
      IMM_I: begin
        instr[31:20] = imm[11:0];
        legal        = fits_signed(imm, I_MSB);
      end
      IMM_S: begin
        instr[31:25] = imm[11:5];
        instr[11:7]  = imm[4:0];
        legal        = fits_signed(imm, S_MSB);
      end
      IMM_SB: begin
        instr[31]    = imm[12];
        instr[7]     = imm[11];
        instr[30:25] = imm[10:5];
        instr[11:8]  = imm[4:1];
        legal        = fits_signed(imm, SB_MSB) && !imm[0];
      end
      IMM_U: begin
        instr[31:12] = imm[31:12];
        legal        = fits_signed(imm, U_MSB) && (imm[U_ALIGN_W-1:0] == '0);
      end
      IMM_UJ: begin
        instr[31]    = imm[20];
        instr[19:12] = imm[19:12];
        instr[20]    = imm[11];
        instr[30:21] = imm[10:1];
        legal        = fits_signed(imm, UJ_MSB) && !imm[0];
      end
      // Selectors 5..7 replace the whole word; the template is ignored.
      default: begin
        instr = imm[31:0];
        legal = fits_signed(imm, RAW_MSB);
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: stage 1 captures the request, stage 2 holds
// the packed word and error flag; illegal requests bump a saturating counter.
module imm_encoder
  import imm_pkg::*;
#(
  parameter bit DROP_ILLEGAL = 1'b0,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_sel,
  input  logic [IMM_W-1:0]     in_imm,
  input  logic [INSTR_W-1:0]   in_base,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INSTR_W-1:0]   out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  // Handshake: a request transfers when in_valid && in_ready, a result when
  // out_valid && out_ready. Both stages shift together whenever the output
  // register is empty or being drained, so in_ready depends only on the
  // output side and a held result never changes.
  logic                 w_adv;
  logic                 r_s1_valid;
  logic [2:0]           r_s1_sel;
  logic [IMM_W-1:0]     r_s1_imm;
  logic [INSTR_W-1:0]   r_s1_base;
  logic [INSTR_W-1:0]   w_pack_instr;
  logic                 w_pack_legal;
  logic                 w_s1_illegal;
  logic                 r_out_valid;
  logic [INSTR_W-1:0]   r_out_instr;
  logic                 r_out_err;
  logic [ERR_CNT_W-1:0] r_err_count;

  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sel   <= '0;
      r_s1_imm   <= '0;
      r_s1_base  <= '0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sel  <= in_sel;
        r_s1_imm  <= in_imm;
        r_s1_base <= in_base;
      end
    end
  end

  // Legality is evaluated from the registered request alongside the packing,
  // so a single packer serves both the range check and the encoding.
  imm_pack u_pack (
    .sel   (r_s1_sel),
    .imm   (r_s1_imm),
    .base  (r_s1_base),
    .instr (w_pack_instr),
    .legal (w_pack_legal)
  );

  assign w_s1_illegal = r_s1_valid && !w_pack_legal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_err   <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_s1_valid && (w_pack_legal || !DROP_ILLEGAL);
      r_out_err   <= w_s1_illegal && !DROP_ILLEGAL;
      if (r_s1_valid) begin
        r_out_instr <= w_pack_instr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_count <= '0;
    end else if (w_adv && w_s1_illegal && (r_err_count != {ERR_CNT_W{1'b1}})) begin
      r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_err   = r_out_err;
  assign err_count = r_err_count;

endmodule
